// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO
// Radix-2 shift-add multiply and restoring divide, one iteration per CALC cycle.
module muldiv_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 2,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic               i_flush,
  input  logic               i_hi_we,
  input  logic               i_lo_we,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NB_OP-1:0]       op_q, op_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]     opnd_q, opnd_d;
  logic                   neg_q, neg_d;
  logic                   rneg_q, rneg_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [NB_DATA-1:0]     hi_q, hi_d;
  logic [NB_DATA-1:0]     lo_q, lo_d;
  logic                   dz_q, dz_d;

  logic                   a_neg, b_neg;
  logic [NB_DATA-1:0]     a_mag, b_mag;
  logic [NB_DATA:0]       rem_sh, rem_diff, sum;
  logic [2*NB_DATA-1:0]   acc_step, prod;
  logic [NB_DATA-1:0]     quot, rem;

  always_comb begin
    a_neg    = i_op[0] & i_data_a[NB_DATA-1];
    b_neg    = i_op[0] & i_data_b[NB_DATA-1];
    a_mag    = a_neg ? -i_data_a : i_data_a;
    b_mag    = b_neg ? -i_data_b : i_data_b;
    rem_sh   = '0;
    rem_diff = '0;
    sum      = '0;
    // opnd_q is the divisor for divides and the multiplicand for multiplies
    if (op_q[1]) begin
      rem_sh = acc_q[2*NB_DATA-1:NB_DATA-1];
      if (rem_sh >= {1'b0, opnd_q}) begin
        rem_diff = rem_sh - {1'b0, opnd_q};
        acc_step = {rem_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_step = {sum, acc_q[NB_DATA-1:1]};
    end
    prod = neg_q ? -acc_step : acc_step;
    quot = neg_q ? -acc_step[NB_DATA-1:0] : acc_step[NB_DATA-1:0];
    rem  = rneg_q ? -acc_step[2*NB_DATA-1:NB_DATA] : acc_step[2*NB_DATA-1:NB_DATA];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (i_flush) begin
          state_d = IDLE;
        end else if (i_start) begin
          op_d  = i_op;
          cnt_d = '0;
          if (i_op[1] && (i_data_b == '0)) begin
            hi_d    = i_data_a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            if (i_op[1]) begin
              acc_d  = {{NB_DATA{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{NB_DATA{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
          end
        end else begin
          if (i_hi_we) hi_d = i_wr_data;
          if (i_lo_we) lo_d = i_wr_data;
        end
      end
      CALC: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == NB_CNT'(NB_DATA-1)) begin
            state_d = DONE;
            if (op_q[1]) begin
              hi_d = rem;
              lo_d = quot;
            end else begin
              hi_d = prod[2*NB_DATA-1:NB_DATA];
              lo_d = prod[NB_DATA-1:0];
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!i_start) begin
          if (i_hi_we) hi_d = i_wr_data;
          if (i_lo_we) lo_d = i_wr_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // The issue cycle stalls combinationally so the instruction holds in EX
  assign o_stall    = ((state_q == IDLE) && i_start && !i_flush) || (state_q == CALC);
  assign o_busy     = (state_q == CALC);
  assign o_done     = (state_q == DONE);
  assign o_div_zero = dz_q;
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = '0;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        i_flush = 1'b0;
  logic        i_hi_we = 1'b0;
  logic        i_lo_we = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic        o_stall, o_busy, o_done, o_div_zero;
  logic [31:0] o_hi, o_lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  muldiv_sequencer #(.NB_DATA(32), .NB_OP(2), .NB_CNT(6)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_flush(i_flush),
    .i_hi_we(i_hi_we), .i_lo_we(i_lo_we), .i_wr_data(i_wr_data),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, q, r;
    sa   = $signed({{32{a[31]}}, a});
    sb64 = $signed({{32{b[31]}}, b});
    case (op)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: return sa * sb64;
      2'd2: if (b == 0) return {a, 32'hFFFFFFFF}; else return {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb64;
        r = sa % sb64;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Issues one operation at a negedge and follows it to o_done (cycle 1 = issue).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int done_cyc, output logic [63:0] res);
    int cyc;
    @(negedge i_clock);
    i_op = op; i_data_a = a; i_data_b = b; i_start = 1'b1;
    #1;
    stalls = o_stall ? 1 : 0;
    done_cyc = 0;
    res = '0;
    cyc = 1;
    while (cyc < 100 && done_cyc == 0) begin
      @(negedge i_clock);
      i_start = 1'b0;
      cyc++;
      if (o_done) begin
        done_cyc = cyc;
        res = {o_hi, o_lo};
      end else if (o_stall) begin
        stalls++;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [63:0] res, input int stalls,
                          input int done_cyc, input int exp_stalls);
    logic [63:0] exp;
    exp = sb.pop_front();
    tests++;
    if (res !== exp) begin
      fails++;
      $display("FAIL %s result got %h exp %h", name, res, exp);
    end
    tests++;
    if (stalls !== exp_stalls || done_cyc !== exp_stalls + 1) begin
      fails++;
      $display("FAIL %s timing stalls=%0d done_cyc=%0d exp %0d/%0d", name, stalls, done_cyc,
               exp_stalls, exp_stalls + 1);
    end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({o_stall, o_busy, o_done, o_div_zero} !== 4'b0 || o_hi !== 0 || o_lo !== 0) begin
      fails++;
      $display("FAIL reset outputs got %b hi=%h lo=%h exp 0", {o_stall, o_busy, o_done, o_div_zero}, o_hi, o_lo);
    end
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  task automatic test_multu;
    int s, d; logic [63:0] r;
    sb.push_back(64'hFFFFFFFE_00000001);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, s, d, r);
    check_op("multu_max", r, s, d, 33);
  endtask

  task automatic test_signed;
    int s, d; logic [63:0] r;
    sb.push_back(64'hFFFFFFFF_FFFFFFD6);
    run_op(2'd1, 32'hFFFFFFF9, 32'd6, s, d, r);
    check_op("mult_neg", r, s, d, 33);
    sb.push_back(64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd3, 32'hFFFFFFF9, 32'd2, s, d, r);
    check_op("div_neg", r, s, d, 33);
  endtask

  task automatic test_divu;
    int s, d; logic [63:0] r;
    sb.push_back({32'd2, 32'd14});
    run_op(2'd2, 32'd100, 32'd7, s, d, r);
    check_op("divu_100_7", r, s, d, 33);
    sb.push_back(64'h00000000_80000000);
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF, s, d, r);
    check_op("div_minint", r, s, d, 33);
    tests++;
    if (o_div_zero !== 1'b0) begin
      fails++;
      $display("FAIL minint_no_flag got %b exp 0", o_div_zero);
    end
  endtask

  task automatic test_div_zero;
    int s, d; logic [63:0] r;
    sb.push_back({32'h00001234, 32'hFFFFFFFF});
    run_op(2'd3, 32'h1234, 32'd0, s, d, r);
    check_op("div_zero", r, s, d, 1);
    tests++;
    if (o_div_zero !== 1'b1) begin
      fails++;
      $display("FAIL div_zero_flag got %b exp 1", o_div_zero);
    end
    sb.push_back({32'd2, 32'd14});
    run_op(2'd2, 32'd100, 32'd7, s, d, r);
    check_op("after_div_zero", r, s, d, 33);
    tests++;
    if (o_div_zero !== 1'b1) begin
      fails++;
      $display("FAIL div_zero_sticky got %b exp 1", o_div_zero);
    end
  endtask

  task automatic test_flush;
    bit seen;
    @(negedge i_clock);
    i_hi_we = 1'b1; i_wr_data = 32'hAAAA0000;
    @(negedge i_clock);
    i_hi_we = 1'b0; i_lo_we = 1'b1; i_wr_data = 32'h00005555;
    @(negedge i_clock);
    i_lo_we = 1'b0;
    tests++;
    if (o_hi !== 32'hAAAA0000 || o_lo !== 32'h00005555) begin
      fails++;
      $display("FAIL mthi_mtlo got %h/%h exp aaaa0000/00005555", o_hi, o_lo);
    end
    i_op = 2'd0; i_data_a = 32'd3; i_data_b = 32'd5; i_start = 1'b1;
    repeat (10) begin
      @(negedge i_clock);
      i_start = 1'b0;
    end
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    tests++;
    if (o_busy !== 1'b0 || o_stall !== 1'b0 || o_hi !== 32'hAAAA0000 || o_lo !== 32'h00005555) begin
      fails++;
      $display("FAIL flush_calc busy=%b stall=%b hi=%h lo=%h exp 0 0 aaaa0000 00005555",
               o_busy, o_stall, o_hi, o_lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge i_clock);
      if (o_done || o_busy) seen = 1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_done got activity=%b exp 0", seen);
    end
    i_start = 1'b1; i_flush = 1'b1;
    #1;
    tests++;
    if (o_stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_stall got %b exp 0", o_stall);
    end
    @(negedge i_clock);
    i_start = 1'b0; i_flush = 1'b0;
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_start got busy=%b exp 0", o_busy);
    end
  endtask

  task automatic test_back_to_back;
    int s, d; logic [63:0] r;
    logic [1:0] op; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a  = $urandom;
      b  = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom);
      sb.push_back(model(op, a, b));
      run_op(op, a, b, s, d, r);
      check_op("b2b_rand", r, s, d, (op[1] && b == 0) ? 1 : 33);
    end
  endtask

  task automatic test_async_reset;
    int s, d; logic [63:0] r;
    @(negedge i_clock);
    i_op = 2'd0; i_data_a = 32'hFFFF; i_data_b = 32'hFFFF; i_start = 1'b1;
    repeat (20) begin
      @(negedge i_clock);
      i_start = 1'b0;
    end
    #2 i_reset = 1'b0;
    #1;
    tests++;
    if ({o_stall, o_busy, o_done, o_div_zero} !== 4'b0 || o_hi !== 0 || o_lo !== 0) begin
      fails++;
      $display("FAIL async_reset got %b hi=%h lo=%h exp 0", {o_stall, o_busy, o_done, o_div_zero}, o_hi, o_lo);
    end
    @(negedge i_clock);
    i_reset = 1'b1;
    sb.push_back(64'd6);
    run_op(2'd0, 32'd2, 32'd3, s, d, r);
    check_op("post_reset_mul", r, s, d, 33);
  endtask

  initial begin
    test_reset;
    test_multu;
    test_signed;
    test_divu;
    test_div_zero;
    test_flush;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine with its own controller, attached beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a radix-2 shift-add multiply or restoring divide over NB_DATA iterations.
- Holds the pipeline with a stall request while it works, and owns the architectural HI/LO registers, which are also written by MTHI/MTLO and read by MFHI/MFLO.

Parameters:
- NB_DATA, 32, operand, HI and LO width.
- NB_OP, 2, operation code width.
- NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > NB_DATA.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  EX holds a mult/div instruction this cycle.
- i_op  in  NB_OP  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- i_data_a  in  NB_DATA  rs operand (multiplicand / dividend), already forwarded.
- i_data_b  in  NB_DATA  rt operand (multiplier / divisor), already forwarded.
- i_flush  in  1  abort the in-flight operation (branch/jump squash).
- i_hi_we  in  1  MTHI write strobe.
- i_lo_we  in  1  MTLO write strobe.
- i_wr_data  in  NB_DATA  MTHI/MTLO data.
- o_stall  out  1  freeze PC, IF/ID, ID/EX.
- o_busy  out  1  state is CALC.
- o_done  out  1  one-cycle pulse; HI/LO hold the new result.
- o_div_zero  out  1  sticky flag, set by DIV/DIVU with divisor 0.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.

Behaviour:
- Reset (async, i_reset=0): state IDLE; HI, LO, counter, working registers all 0; o_stall=0, o_busy=0, o_done=0, o_div_zero=0.
- States: IDLE, CALC, DONE.
- IDLE, o_stall = i_start, combinational, so the issuing instruction is held from its first EX cycle.
- IDLE with i_start=1:
  - Latch op; latch the magnitudes of a and b (two's-complement absolute value only for op 01/11); latch the result sign; counter=0.
  - Divide with b=0: HI<=a, LO<=all ones, o_div_zero<=1, go to DONE.
  - Otherwise go to CALC.
- CALC, o_stall=1, o_busy=1. Each cycle performs one iteration, then counter++.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper partial product; shift the 2*NB_DATA accumulator right by 1.
  - Divide: shift the remainder:quotient pair left by 1; trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set quotient LSB to 1.
  - When counter==NB_DATA-1, apply sign correction, write HI/LO, go to DONE.
- Sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative if the signs differ; remainder takes the dividend's sign.
  - DIV of 0x80000000 by -1 gives LO=0x80000000, HI=0; no flag.
- Result mapping: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
- DONE, o_stall=0, o_done=1 for exactly one cycle; next state IDLE unconditionally. A new i_start in DONE is ignored; EX re-presents it next cycle in IDLE.
- Latency: issue cycle plus 32 CALC cycles gives 33 stall cycles; o_done appears in cycle 34. A divide by zero gives 1 stall cycle.
- i_flush:
  - In CALC: return to IDLE next edge; HI/LO unchanged; no o_done.
  - In IDLE: blocks start (flush has priority over i_start, and o_stall=0).
  - In DONE: no effect, because the result has already been committed.
- MTHI/MTLO: honoured only in IDLE and DONE. In those states, a same-cycle i_start has priority over i_hi_we/i_lo_we. In CALC, the strobes are ignored; the stall guarantees they cannot legally occur.
- o_div_zero clears only on reset.
- Counter never wraps: it is reset on every start, and CALC exits at NB_DATA-1.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> o_stall high 33 cycles; o_done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=-7 (0xFFFFFFF9), b=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6; DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 -> LO=14, HI=2; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, o_div_zero=0.
- DIV a=0x1234, b=0 -> 1 stall cycle; next cycle o_done=1, HI=0x1234, LO=0xFFFFFFFF, o_div_zero=1 and stays 1.
- MTHI 0xAAAA0000 then MTLO 0x5555; start MULTU 3*5; assert i_flush at CALC cycle 10 -> back to IDLE; HI=0xAAAA0000, LO=0x5555 unchanged; no o_done.
- Assert i_reset low mid-CALC (cycle 20) -> all outputs 0 immediately without waiting for a clock edge; after release, a MULTU 2*3 completes normally with LO=6, HI=0.
